// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sched_pkg
// Description : Shared types and width defaults for cache_mem_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package sched_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

endpackage
`default_nettype wire

// File: rtl/cache_mem_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_scheduler_if
// Description : Cache-side request/response and memory-port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_mem_scheduler_if;
  import sched_pkg::*;

  logic              mem_read_i;
  logic              mem_write_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [LINE_W-1:0] wdata_i;
  logic              mem_read_d;
  logic              mem_write_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [LINE_W-1:0] wdata_d;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic              mem_resp_i;
  logic              mem_resp_d;
  logic [LINE_W-1:0] inst_rdata;
  logic [LINE_W-1:0] data_rdata;

  modport slave (
    input  mem_read_i, mem_write_i, mem_addr_i, wdata_i,
    input  mem_read_d, mem_write_d, mem_addr_d, wdata_d,
    input  pmem_resp, pmem_rdata,
    output pmem_read, pmem_write, pmem_addr, pmem_wdata,
    output mem_resp_i, mem_resp_d, inst_rdata, data_rdata
  );

  modport master (
    output mem_read_i, mem_write_i, mem_addr_i, wdata_i,
    output mem_read_d, mem_write_d, mem_addr_d, wdata_d,
    output pmem_resp, pmem_rdata,
    input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
    input  mem_resp_i, mem_resp_d, inst_rdata, data_rdata
  );

endinterface
`default_nettype wire

// File: rtl/rr_grant2.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant2
// Description : Combinational two-way round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant2
  import sched_pkg::*;
(
  input  logic [1:0] pending,      // bit 0 = I-cache, bit 1 = D-cache
  input  req_id_e    last_grant,
  output logic       grant_valid,
  output req_id_e    grant_id
);

  always_comb begin
    grant_valid = |pending;
    grant_id    = REQ_I;
    if (pending == 2'b11) begin
      grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (pending[1]) begin
      grant_id = REQ_D;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_scheduler
// Description : Shares one physical-memory port between I-cache and D-cache
//               with round-robin arbitration. Optional SCHED_PERF_EN adds
//               grant/contention counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_scheduler
  import sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  cache_mem_scheduler_if.slave  bus
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]           perf_grant_i,
  output logic [31:0]           perf_grant_d,
  output logic [31:0]           perf_contend
`endif
);

  sched_state_e      state;
  sched_state_e      state_nx;
  req_id_e           last_grant;
  req_id_e           owner;
  req_id_e           grant_id;
  logic              grant_valid;
  logic [1:0]        pending;
  logic              do_grant;
  logic              do_done;

  logic              cmd_read;
  logic              cmd_write;
  logic              cmd_is_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LINE_W-1:0] cmd_wdata;
  logic              resp_inst;
  logic              resp_data;
  logic [LINE_W-1:0] inst_line;
  logic [LINE_W-1:0] data_line;

  assign pending = {bus.mem_read_d | bus.mem_write_d,
                    bus.mem_read_i | bus.mem_write_i};

  rr_grant2 u_rr_grant2 (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_nx = state;
    do_grant = 1'b0;
    do_done  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          do_grant = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (bus.pmem_resp) begin
          do_done  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Read+write asserted together is treated as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant   <= REQ_I;
      owner        <= REQ_I;
      cmd_read     <= 1'b0;
      cmd_write    <= 1'b0;
      cmd_is_write <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      resp_inst    <= 1'b0;
      resp_data    <= 1'b0;
      inst_line    <= '0;
      data_line    <= '0;
    end else begin
      resp_inst <= do_done && (owner == REQ_I);
      resp_data <= do_done && (owner == REQ_D);
      if (do_grant) begin
        owner <= grant_id;
        if (grant_id == REQ_D) begin
          cmd_is_write <= bus.mem_write_d;
          cmd_read     <= ~bus.mem_write_d;
          cmd_write    <= bus.mem_write_d;
          cmd_addr     <= bus.mem_addr_d;
          cmd_wdata    <= bus.wdata_d;
        end else begin
          cmd_is_write <= bus.mem_write_i;
          cmd_read     <= ~bus.mem_write_i;
          cmd_write    <= bus.mem_write_i;
          cmd_addr     <= bus.mem_addr_i;
          cmd_wdata    <= bus.wdata_i;
        end
      end
      if (do_done) begin
        cmd_read   <= 1'b0;
        cmd_write  <= 1'b0;
        last_grant <= owner;
        if (!cmd_is_write) begin
          if (owner == REQ_D) begin
            data_line <= bus.pmem_rdata;
          end else begin
            inst_line <= bus.pmem_rdata;
          end
        end
      end
    end
  end

  assign bus.pmem_read  = cmd_read;
  assign bus.pmem_write = cmd_write;
  assign bus.pmem_addr  = cmd_addr;
  assign bus.pmem_wdata = cmd_wdata;
  assign bus.mem_resp_i = resp_inst;
  assign bus.mem_resp_d = resp_data;
  assign bus.inst_rdata = inst_line;
  assign bus.data_rdata = data_line;

`ifdef SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_grant_i <= '0;
      perf_grant_d <= '0;
      perf_contend <= '0;
    end else begin
      if (do_grant && (grant_id == REQ_I)) perf_grant_i <= perf_grant_i + 32'd1;
      if (do_grant && (grant_id == REQ_D)) perf_grant_d <= perf_grant_d + 32'd1;
      if ((state == IDLE) && (pending == 2'b11)) perf_contend <= perf_contend + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_scheduler
// Description : Directed self-checking bench for cache_mem_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [255:0] LINE_A = {32{8'hAA}};
  localparam logic [255:0] LINE_B = {32{8'hBB}};
  localparam logic [255:0] LINE_C = {32{8'hCC}};
  localparam logic [255:0] LINE_E = {32{8'hEE}};
  localparam logic [255:0] WLINE  = {16{16'h1234}};

  always #5 clk = ~clk;

  cache_mem_scheduler_if bus ();

`ifdef SCHED_PERF_EN
  logic [31:0] perf_grant_i;
  logic [31:0] perf_grant_d;
  logic [31:0] perf_contend;
`endif

  cache_mem_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SCHED_PERF_EN
    ,
    .perf_grant_i (perf_grant_i),
    .perf_grant_d (perf_grant_d),
    .perf_contend (perf_contend)
`endif
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.mem_read_i  = 1'b0;
    bus.mem_write_i = 1'b0;
    bus.mem_addr_i  = '0;
    bus.wdata_i     = '0;
    bus.mem_read_d  = 1'b0;
    bus.mem_write_d = 1'b0;
    bus.mem_addr_d  = '0;
    bus.wdata_d     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_reqs();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Waits gap cycles then pulses pmem_resp; returns in the response cycle.
  task automatic mem_respond(input logic [255:0] rd, input int gap);
    repeat (gap) tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rd;
    tick();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_d;

    // Reset values and single I-cache read
    do_reset();
    check("rst_pmem_read",  bus.pmem_read,  0);
    check("rst_pmem_write", bus.pmem_write, 0);
    check("rst_pmem_addr",  bus.pmem_addr,  0);
    check("rst_pmem_wdata", bus.pmem_wdata, 0);
    check("rst_resp_i",     bus.mem_resp_i, 0);
    check("rst_resp_d",     bus.mem_resp_d, 0);
    check("rst_inst_rdata", bus.inst_rdata, 0);
    check("rst_data_rdata", bus.data_rdata, 0);

    bus.mem_read_i = 1'b1;
    bus.mem_addr_i = 32'h0000_0040;
    tick();
    check("t1_pmem_read",  bus.pmem_read,  1);
    check("t1_pmem_write", bus.pmem_write, 0);
    check("t1_pmem_addr",  bus.pmem_addr,  32'h40);
    mem_respond(LINE_A, 2);
    check("t1_resp_i",     bus.mem_resp_i, 1);
    check("t1_resp_d",     bus.mem_resp_d, 0);
    check("t1_inst_rdata", bus.inst_rdata, LINE_A);
    check("t1_data_rdata", bus.data_rdata, 0);
    check("t1_cmd_drop",   bus.pmem_read,  0);
    bus.mem_read_i = 1'b0;
    tick();
    check("t1_resp_i_one", bus.mem_resp_i, 0);
    tick();
    check("t1_no_regrant", bus.pmem_read,  0);

    // Simultaneous reads after reset: D first, then I
    do_reset();
    bus.mem_read_i = 1'b1;
    bus.mem_addr_i = 32'h0000_0100;
    bus.mem_read_d = 1'b1;
    bus.mem_addr_d = 32'h0000_0200;
    tick();
    check("t2_first_addr", bus.pmem_addr, 32'h200);
    check("t2_first_read", bus.pmem_read, 1);
    mem_respond(LINE_B, 1);
    check("t2_resp_d",     bus.mem_resp_d, 1);
    check("t2_resp_i",     bus.mem_resp_i, 0);
    check("t2_data_rdata", bus.data_rdata, LINE_B);
    check("t2_inst_rdata", bus.inst_rdata, 0);
    bus.mem_read_d = 1'b0;
    tick();
    check("t2_idle_gap",   bus.pmem_read, 0);
    tick();
    check("t2_second_addr", bus.pmem_addr, 32'h100);
    check("t2_second_read", bus.pmem_read, 1);
    mem_respond(LINE_C, 0);
    check("t2_resp_i2",     bus.mem_resp_i, 1);
    check("t2_inst_rdata2", bus.inst_rdata, LINE_C);
    check("t2_data_keep",   bus.data_rdata, LINE_B);
    bus.mem_read_i = 1'b0;
    tick();

    // D write while I requests continuously (last grant was I, so D wins)
    bus.mem_write_d = 1'b1;
    bus.mem_addr_d  = 32'h0000_1000;
    bus.wdata_d     = WLINE;
    bus.mem_read_i  = 1'b1;
    bus.mem_addr_i  = 32'h0000_0040;
    tick();
    check("t3_pmem_write", bus.pmem_write, 1);
    check("t3_pmem_read",  bus.pmem_read,  0);
    check("t3_pmem_addr",  bus.pmem_addr,  32'h1000);
    check("t3_pmem_wdata", bus.pmem_wdata, WLINE);
    bus.wdata_d = LINE_E;
    repeat (2) tick();
    check("t3_wdata_hold", bus.pmem_wdata, WLINE);
    check("t3_write_hold", bus.pmem_write, 1);
    mem_respond(LINE_E, 0);
    check("t3_resp_d",     bus.mem_resp_d, 1);
    check("t3_no_capture", bus.data_rdata, LINE_B);
    check("t3_write_drop", bus.pmem_write, 0);
    bus.mem_write_d = 1'b0;
    repeat (2) tick();
    check("t3_i_addr",     bus.pmem_addr, 32'h40);
    check("t3_i_read",     bus.pmem_read, 1);
    mem_respond(LINE_A, 0);
    check("t3_resp_i",     bus.mem_resp_i, 1);
    bus.mem_read_i = 1'b0;
    tick();

    // Both held; owner re-requests after each response -> strict alternation D,I,D,I
    bus.mem_read_i = 1'b1;
    bus.mem_addr_i = 32'h0000_0040;
    bus.mem_read_d = 1'b1;
    bus.mem_addr_d = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      tick();
      check($sformatf("alt%0d_addr", k), bus.pmem_addr, exp_d ? 32'h2000 : 32'h40);
      mem_respond(LINE_C, 1);
      check($sformatf("alt%0d_resp_d", k), bus.mem_resp_d, exp_d);
      check($sformatf("alt%0d_resp_i", k), bus.mem_resp_i, !exp_d);
      if (exp_d) bus.mem_read_d = 1'b0;
      else       bus.mem_read_i = 1'b0;
      tick();
      bus.mem_read_i = 1'b1;
      bus.mem_read_d = 1'b1;
    end

    // Spurious pmem_resp in IDLE
    do_reset();
    tick();
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    check("t4_resp_i", bus.mem_resp_i, 0);
    check("t4_resp_d", bus.mem_resp_d, 0);
    check("t4_read",   bus.pmem_read,  0);
    bus.mem_read_i = 1'b1;
    bus.mem_addr_i = 32'h0000_0300;
    tick();
    check("t4_grant_read", bus.pmem_read, 1);
    check("t4_grant_addr", bus.pmem_addr, 32'h300);
    mem_respond(LINE_B, 0);
    check("t4_resp_i_ok",  bus.mem_resp_i, 1);
    bus.mem_read_i = 1'b0;
    tick();

    // Reset asserted mid-BUSY
    do_reset();
    bus.mem_read_i = 1'b1;
    bus.mem_addr_i = 32'h0000_0080;
    tick();
    check("t5_busy_read", bus.pmem_read, 1);
    #1 rst = 1'b0;
    #1;
    check("t5_async_drop", bus.pmem_read, 0);
    check("t5_addr_clear", bus.pmem_addr, 0);
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    check("t5_no_resp", bus.mem_resp_i, 0);
    rst = 1'b1;
    check("t5_still_low", bus.pmem_read, 0);
    tick();
    check("t5_regrant_read", bus.pmem_read, 1);
    check("t5_regrant_addr", bus.pmem_addr, 32'h80);
    mem_respond(LINE_C, 0);
    check("t5_resp_i", bus.mem_resp_i, 1);
    check("t5_inst",   bus.inst_rdata, LINE_C);
    bus.mem_read_i = 1'b0;
    tick();

`ifdef SCHED_PERF_EN
    // Two contention episodes
    do_reset();
    for (int e = 0; e < 2; e++) begin
      bus.mem_read_i = 1'b1;
      bus.mem_addr_i = 32'h0000_0400;
      bus.mem_read_d = 1'b1;
      bus.mem_addr_d = 32'h0000_0800;
      tick();
      mem_respond(LINE_A, 0);
      bus.mem_read_d = 1'b0;
      repeat (2) tick();
      mem_respond(LINE_B, 0);
      bus.mem_read_i = 1'b0;
      tick();
    end
    check("perf_contend", perf_contend, 2);
    check("perf_grant_i", perf_grant_i, 2);
    check("perf_grant_d", perf_grant_d, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
